// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding and
// architectural constants.
package fetch_unit_pkg;

    typedef enum logic [2:0] {
        START  = 3'd0,
        REQ    = 3'd1,
        WAIT   = 3'd2,
        VALID  = 3'd3,
        HALTED = 3'd4
    } fetch_state_e;

    localparam logic [15:0] RESET_PC    = 16'h0000;
    localparam logic [15:0] NOP_INSTR   = 16'h0800;
    localparam logic [4:0]  HALT_OPCODE = 5'b00000;

    // Instructions are halfword aligned, so any odd target is illegal.
    function automatic logic isMisaligned(input logic [15:0] addr);
        return addr[0];
    endfunction

endpackage

// File: rtl/fetch_unit_pc_adder.sv
// Wrapping +2 incrementer shared by the link value and sequential fetch.
module pc_adder (
    input  logic [15:0] pcIn,
    output logic [15:0] pcOut
);

    assign pcOut = pcIn + 16'd2;

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit: requests one word at a time,
// presents it to decode and follows sequential, redirect and halt flow.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        imemReq,
    output logic [15:0] imemAddr,
    input  logic        imemGnt,
    input  logic        imemRdy,
    input  logic [15:0] imemData,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirectPc,
    input  logic        halt,
    output logic [15:0] instr,
    output logic        instrValid,
    output logic [15:0] pc,
    output logic [15:0] pcPlus2,
    output logic        halted,
    output logic        err
);

    fetch_state_e state, nextState;
    logic [15:0]  fetchPc, nextFetchPc;
    logic         loadInstr;
    logic         setErr;

    pc_adder pcInc (
        .pcIn  (pc),
        .pcOut (pcPlus2)
    );

    always_comb begin
        nextState   = state;
        nextFetchPc = fetchPc;
        loadInstr   = 1'b0;
        setErr      = 1'b0;
        unique case (state)
            START:  nextState = REQ;
            REQ:    if (imemGnt) nextState = WAIT;
            WAIT: begin
                if (imemRdy) begin
                    loadInstr = 1'b1;
                    nextState = VALID;
                end
            end
            VALID: begin
                // Control inputs only matter at the moment decode consumes.
                if (!stall) begin
                    if (halt) begin
                        nextState = HALTED;
                    end else if (redirect && isMisaligned(redirectPc)) begin
                        setErr    = 1'b1;
                        nextState = HALTED;
                    end else if (redirect) begin
                        nextFetchPc = redirectPc;
                        nextState   = REQ;
                    end else begin
                        nextFetchPc = pcPlus2;
                        nextState   = REQ;
                    end
                end
            end
            HALTED: nextState = HALTED;
            default: nextState = START;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= START;
            fetchPc <= RESET_PC;
            pc      <= RESET_PC;
            instr   <= NOP_INSTR;
            err     <= 1'b0;
        end else begin
            state   <= nextState;
            fetchPc <= nextFetchPc;
            if (loadInstr) begin
                instr <= imemData;
                pc    <= fetchPc;
            end
            if (setErr) err <= 1'b1;
        end
    end

    assign imemReq    = (state == REQ);
    assign imemAddr   = fetchPc;
    assign instrValid = (state == VALID);
    assign halted     = (state == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with a hand-stepped memory.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imemReq;
    logic [15:0] imemAddr;
    logic        imemGnt;
    logic        imemRdy;
    logic [15:0] imemData;
    logic        stall;
    logic        redirect;
    logic [15:0] redirectPc;
    logic        halt;
    logic [15:0] instr;
    logic        instrValid;
    logic [15:0] pc;
    logic [15:0] pcPlus2;
    logic        halted;
    logic        err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        int          gntDelay;
        int          rdyDelay;
        int          stallCycles;
        logic        stallRedirect;
        logic        redirect;
        logic [15:0] redirectPc;
        logic        halt;
        logic [15:0] expPcPlus2;
        logic [15:0] nextAddr;
        logic        expHalted;
        logic        expErr;
    } vec_t;

    vec_t vecs [9];

    fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemGnt    (imemGnt),
        .imemRdy    (imemRdy),
        .imemData   (imemData),
        .stall      (stall),
        .redirect   (redirect),
        .redirectPc (redirectPc),
        .halt       (halt),
        .instr      (instr),
        .instrValid (instrValid),
        .pc         (pc),
        .pcPlus2    (pcPlus2),
        .halted     (halted),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic waitReq(input logic [15:0] expAddr);
        int n;
        n = 0;
        while (imemReq !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("reqSeen", {15'd0, imemReq}, 16'd1);
        check("imemAddr", imemAddr, expAddr);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        imemGnt = 1'b0; imemRdy = 1'b0; imemData = 16'h0000;
        stall = 1'b0; redirect = 1'b0; redirectPc = 16'h0000; halt = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic applyStimulus(input vec_t v);
        waitReq(v.addr);
        for (int i = 0; i < v.gntDelay; i++) begin
            tick();
            check("reqHeld", {15'd0, imemReq}, 16'd1);
            check("addrStable", imemAddr, v.addr);
        end
        imemGnt = 1'b1;
        tick();
        imemGnt = 1'b0;
        check("reqDropInWait", {15'd0, imemReq}, 16'd0);
        for (int i = 0; i < v.rdyDelay; i++) begin
            tick();
            check("noDupReq", {15'd0, imemReq}, 16'd0);
            check("notValidYet", {15'd0, instrValid}, 16'd0);
        end
        imemData = v.data;
        imemRdy  = 1'b1;
        tick();
        imemRdy  = 1'b0;
        imemData = 16'hBAD0;
        check("instrValid", {15'd0, instrValid}, 16'd1);
        check("instr", instr, v.data);
        check("pc", pc, v.addr);
        check("pcPlus2", pcPlus2, v.expPcPlus2);
        stall      = 1'b1;
        redirect   = v.stallRedirect;
        redirectPc = 16'h0200;
        for (int i = 0; i < v.stallCycles; i++) begin
            tick();
            check("stallValid", {15'd0, instrValid}, 16'd1);
            check("stallInstr", instr, v.data);
            check("stallPc", pc, v.addr);
            check("stallNoReq", {15'd0, imemReq}, 16'd0);
        end
        stall      = 1'b0;
        redirect   = v.redirect;
        redirectPc = v.redirectPc;
        halt       = v.halt;
        tick();
        redirect   = 1'b0;
        redirectPc = 16'h0000;
        halt       = 1'b0;
    endtask

    task automatic checkOutput(input vec_t v);
        check("halted", {15'd0, halted}, {15'd0, v.expHalted});
        check("err", {15'd0, err}, {15'd0, v.expErr});
        check("validAfterConsume", {15'd0, instrValid}, 16'd0);
        if (v.expHalted) begin
            check("haltNoReq", {15'd0, imemReq}, 16'd0);
        end else begin
            check("nextReq", {15'd0, imemReq}, 16'd1);
            check("nextAddr", imemAddr, v.nextAddr);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t misVec;
        //                addr      data      gd rd st sr    rd    rpc       h     pp2       next      hl    e
        vecs[0] = '{16'h0000, 16'h4001, 0, 0, 0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0002, 16'h0002, 1'b0, 1'b0};
        vecs[1] = '{16'h0002, 16'h4002, 3, 2, 0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0004, 16'h0004, 1'b0, 1'b0};
        vecs[2] = '{16'h0004, 16'h4001, 0, 0, 5, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0006, 16'h0006, 1'b0, 1'b0};
        vecs[3] = '{16'h0006, 16'h4003, 1, 1, 3, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0008, 16'h0008, 1'b0, 1'b0};
        vecs[4] = '{16'h0008, 16'h6804, 0, 0, 0, 1'b0, 1'b1, 16'h0010, 1'b0, 16'h000A, 16'h0010, 1'b0, 1'b0};
        vecs[5] = '{16'h0010, 16'h6808, 0, 1, 2, 1'b1, 1'b1, 16'h0100, 1'b0, 16'h0012, 16'h0100, 1'b0, 1'b0};
        vecs[6] = '{16'h0100, 16'h680C, 2, 0, 0, 1'b0, 1'b1, 16'hFFFE, 1'b0, 16'h0102, 16'hFFFE, 1'b0, 1'b0};
        vecs[7] = '{16'hFFFE, 16'h4005, 0, 0, 0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[8] = '{16'h0000, 16'h0000, 0, 0, 0, 1'b0, 1'b1, 16'h0101, 1'b1, 16'h0002, 16'h0000, 1'b1, 1'b0};

        // Reset values and the START cycle with no request.
        doReset();
        rst_n = 1'b0;
        #1;
        check("rstInstr", instr, 16'h0800);
        check("rstPc", pc, 16'h0000);
        check("rstPcPlus2", pcPlus2, 16'h0002);
        check("rstValid", {15'd0, instrValid}, 16'd0);
        check("rstReq", {15'd0, imemReq}, 16'd0);
        check("rstHalted", {15'd0, halted}, 16'd0);
        check("rstErr", {15'd0, err}, 16'd0);
        rst_n = 1'b1;
        check("startNoReq", {15'd0, imemReq}, 16'd0);
        tick();
        check("firstReq", {15'd0, imemReq}, 16'd1);
        check("firstAddr", imemAddr, 16'h0000);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i]);
        end

        // HALTED is sticky and ignores memory and control inputs.
        for (int i = 0; i < 5; i++) begin
            imemRdy  = 1'b1;
            imemGnt  = 1'b1;
            redirect = 1'b1;
            redirectPc = 16'h0040;
            tick();
            check("haltedSticky", {15'd0, halted}, 16'd1);
            check("haltedNoReq", {15'd0, imemReq}, 16'd0);
            check("haltedNoValid", {15'd0, instrValid}, 16'd0);
        end
        imemRdy = 1'b0; imemGnt = 1'b0; redirect = 1'b0; redirectPc = 16'h0000;

        // Misaligned redirect target raises err and halts.
        doReset();
        misVec = '{16'h0000, 16'h4001, 0, 0, 0, 1'b0, 1'b1, 16'h0101, 1'b0, 16'h0002, 16'h0000, 1'b1, 1'b1};
        applyStimulus(misVec);
        checkOutput(misVec);
        tick();
        tick();
        check("errSticky", {15'd0, err}, 16'd1);
        check("errHalted", {15'd0, halted}, 16'd1);

        // Reset mid-WAIT, then a late imemRdy must be dropped.
        doReset();
        waitReq(16'h0000);
        imemGnt = 1'b1;
        tick();
        imemGnt = 1'b0;
        check("inWait", {15'd0, imemReq}, 16'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        imemRdy  = 1'b1;
        imemData = 16'hDEAD;
        tick();
        check("lateRdyValid", {15'd0, instrValid}, 16'd0);
        check("lateRdyInstr", instr, 16'h0800);
        check("restartReq", {15'd0, imemReq}, 16'd1);
        check("restartAddr", imemAddr, 16'h0000);
        tick();
        imemRdy = 1'b0;
        check("rdyInReqIgnored", {15'd0, instrValid}, 16'd0);
        check("stillReq", {15'd0, imemReq}, 16'd1);
        check("stillAddr", imemAddr, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
